demux_1_4_stream: RTL and testbench

//  Registered 1-to-4 demultiplexer with valid/ready handshake; the receive-side counterpart of the 4:1 mux.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_lane_reg.sv | 35 +++
 rtl/demux_1_4_stream.sv | 78 +++++++
 tb/tb_demux_1_4_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, lane index type and one-hot lane decode for the 1:4 stream demux.
package demux_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_IDX_W = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
    lane_onehot = NUM_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output register slice: loads on ld, drains on q_ready, reports when it can take a word.
module demux_lane_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             free
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  // A load wins over a drain so a full lane can be refilled in the cycle it empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (ld) begin
      r_q     <= d;
      r_valid <= 1'b1;
    end else if (q_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign q       = r_q;
  assign q_valid = r_valid;
  assign free    = !r_valid || q_ready;

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 demultiplexer with valid/ready handshake; fixed select or round-robin de-interleave.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             rr_en,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  output logic             y3_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  input  logic             y3_ready,
  output logic [1:0]       sel_q
);

  lane_idx_t            r_sel_q;
  lane_idx_t            w_sel;
  logic                 w_accept;
  logic [NUM_LANES-1:0] w_free;
  logic [NUM_LANES-1:0] w_ld;
  logic [NUM_LANES-1:0] w_valid;
  logic [NUM_LANES-1:0] w_ready;
  logic [WIDTH-1:0]     w_q [NUM_LANES];

  // Only the selected lane's occupancy gates the input; other lanes never block it.
  assign w_sel    = rr_en ? r_sel_q : {s1, s0};
  assign x_ready  = !rst && w_free[w_sel];
  assign w_accept = x_valid && x_ready;
  assign w_ld     = w_accept ? lane_onehot(w_sel) : '0;
  assign w_ready  = {y3_ready, y2_ready, y1_ready, y0_ready};

  // Pointer advances only on round-robin accepts and survives rr_en toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_q <= '0;
    end else if (w_accept && rr_en) begin
      r_sel_q <= r_sel_q + 2'd1;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld      (w_ld[k]),
      .d       (x),
      .q       (w_q[k]),
      .q_valid (w_valid[k]),
      .q_ready (w_ready[k]),
      .free    (w_free[k])
    );
  end

  assign y0       = w_q[0];
  assign y1       = w_q[1];
  assign y2       = w_q[2];
  assign y3       = w_q[3];
  assign y0_valid = w_valid[0];
  assign y1_valid = w_valid[1];
  assign y2_valid = w_valid[2];
  assign y3_valid = w_valid[3];
  assign sel_q    = r_sel_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: lane-array reference model checked every cycle plus directed literal checks.
module tb_demux_1_4_stream;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x;
  logic         x_valid, x_ready, s0, s1, rr_en;
  logic [W-1:0] y0, y1, y2, y3;
  logic         y0_valid, y1_valid, y2_valid, y3_valid;
  logic         y0_ready, y1_ready, y2_ready, y3_ready;
  logic [1:0]   sel_q;

  int n_vec = 0;
  int n_err = 0;

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .s0(s0), .s1(s1), .rr_en(rr_en),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid), .y3_valid(y3_valid),
    .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready), .y3_ready(y3_ready),
    .sel_q(sel_q)
  );

  always #5 clk = ~clk;

  // Reference model: four single-word lanes and a pointer.
  logic [W-1:0] m_data  [4] = '{default: '0};
  logic         m_valid [4] = '{default: 1'b0};
  int           m_ptr   = 0;
  bit           chk_en  = 1'b0;

  function automatic logic [W-1:0] dut_data(input int k);
    case (k)
      0: return y0;
      1: return y1;
      2: return y2;
      default: return y3;
    endcase
  endfunction

  function automatic logic dut_valid(input int k);
    case (k)
      0: return y0_valid;
      1: return y1_valid;
      2: return y2_valid;
      default: return y3_valid;
    endcase
  endfunction

  function automatic logic lane_ready(input int k);
    case (k)
      0: return y0_ready;
      1: return y1_ready;
      2: return y2_ready;
      default: return y3_ready;
    endcase
  endfunction

  function automatic int target_lane();
    return rr_en ? m_ptr : (int'(s1) * 2 + int'(s0));
  endfunction

  function automatic logic model_ready();
    int t;
    t = target_lane();
    return !rst && (!m_valid[t] || lane_ready(t));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  t;
    bit  acc;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k]  = '0;
        m_valid[k] = 1'b0;
      end
      m_ptr  = 0;
      chk_en = 1'b1;
    end else begin
      t   = target_lane();
      acc = x_valid && model_ready();
      for (int k = 0; k < 4; k++) begin
        if (acc && t == k) begin
          m_data[k]  = x;
          m_valid[k] = 1'b1;
        end else if (lane_ready(k)) begin
          m_valid[k] = 1'b0;
        end
      end
      if (acc && rr_en) m_ptr = (m_ptr + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_x_ready", 32'(x_ready), 32'(model_ready()));
      check("model_sel_q", 32'(sel_q), 32'(m_ptr));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model_y%0d_valid", k), 32'(dut_valid(k)), 32'(m_valid[k]));
        check($sformatf("model_y%0d_data", k), 32'(dut_data(k)), 32'(m_data[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    s1 = 1'((s >> 1) & 1);
    s0 = 1'(s & 1);
  endtask

  initial begin
    rst = 1'b1; x = '0; x_valid = 1'b0; s0 = 1'b0; s1 = 1'b0; rr_en = 1'b0;
    y0_ready = 1'b1; y1_ready = 1'b1; y2_ready = 1'b1; y3_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_sel_q", 32'(sel_q), 32'd0);
    check("rst_y0_valid", 32'(y0_valid), 32'd0);

    // Fixed routing, one word per lane.
    rst = 1'b0; x_valid = 1'b1;
    set_sel(0); x = 8'h11; step();
    set_sel(1); x = 8'h22;
    @(negedge clk); check("fix_y0_valid", 32'(y0_valid), 32'd1); check("fix_y0", 32'(y0), 32'h11);
    step();
    set_sel(2); x = 8'h33;
    @(negedge clk); check("fix_y1", 32'(y1), 32'h22); check("fix_y0_drained", 32'(y0_valid), 32'd0);
    step();
    set_sel(3); x = 8'h44;
    @(negedge clk); check("fix_y2", 32'(y2), 32'h33);
    step();
    x_valid = 1'b0;
    @(negedge clk); check("fix_y3_valid", 32'(y3_valid), 32'd1); check("fix_y3", 32'(y3), 32'h44);
    step();

    // Backpressure on lane 2 does not block lane 0.
    y2_ready = 1'b0; x_valid = 1'b1;
    set_sel(2); x = 8'h55; step();
    set_sel(0); x = 8'h77;
    @(negedge clk); check("bp_x_ready_lane0", 32'(x_ready), 32'd1);
    step();
    set_sel(2); x = 8'h66;
    @(negedge clk); check("bp_y0", 32'(y0), 32'h77); check("bp_stall", 32'(x_ready), 32'd0);
    step();
    @(negedge clk); check("bp_y2_held", 32'(y2), 32'h55); check("bp_still_stall", 32'(x_ready), 32'd0);
    y2_ready = 1'b1;
    #1 check("bp_release", 32'(x_ready), 32'd1);
    step();
    x_valid = 1'b0;
    @(negedge clk); check("bp_y2_valid", 32'(y2_valid), 32'd1); check("bp_y2_new", 32'(y2), 32'h66);
    step();

    // Round-robin de-interleave with select bits ignored.
    rr_en = 1'b1; set_sel(3); x_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 8'hA0 + 8'(i);
      step();
      @(negedge clk);
      check($sformatf("rr_lane%0d_valid", i % 4), 32'(dut_valid(i % 4)), 32'd1);
      check($sformatf("rr_word%0d", i), 32'(dut_data(i % 4)), 32'(8'hA0 + 8'(i)));
    end
    check("rr_sel_q_end", 32'(sel_q), 32'd2);
    x_valid = 1'b0;
    step();

    // Same-lane drain and reload without a bubble.
    rr_en = 1'b0; set_sel(1); x_valid = 1'b1; x = 8'hB1;
    step();
    x = 8'hB2;
    @(negedge clk); check("dl_x_ready_full", 32'(x_ready), 32'd1); check("dl_y1_first", 32'(y1), 32'hB1);
    step();
    x_valid = 1'b0;
    @(negedge clk); check("dl_y1_valid", 32'(y1_valid), 32'd1); check("dl_y1_second", 32'(y1), 32'hB2);
    step();

    // Mid-stream reset with pointer at 3 and lane 3 full.
    y3_ready = 1'b0; set_sel(3); x_valid = 1'b1; x = 8'hD3;
    step();
    rr_en = 1'b1; x = 8'hC2;
    step();
    x_valid = 1'b0;
    @(negedge clk); check("mr_sel_q_pre", 32'(sel_q), 32'd3); check("mr_y3_full", 32'(y3_valid), 32'd1);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mr_y3_valid", 32'(y3_valid), 32'd0); check("mr_y3_zero", 32'(y3), 32'd0);
    check("mr_sel_q", 32'(sel_q), 32'd0); check("mr_x_ready", 32'(x_ready), 32'd0);
    rst = 1'b0; x_valid = 1'b1; x = 8'hE0;
    step();
    x_valid = 1'b0;
    @(negedge clk); check("mr_first_y0", 32'(y0), 32'hE0); check("mr_first_y0_valid", 32'(y0_valid), 32'd1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
